ac97_pcm_fifo: RTL

// - Playback sample buffer that sits directly upstream of the AC-link serializer.
// - Accepts stereo PCM pairs from a producer (wave generator, DMA) over a valid/ready handshake.
// - Buffers the pairs in a FIFO and presents one pair per AC97 frame on slot3 (left) and slot4 (right).
// - Primes before playback, emits silence on underrun, and counts underruns.

---
 rtl/ac97_pkg.sv | 30 +++
 rtl/ac97_sync_fifo.sv | 112 +++++++++++
 rtl/ac97_pcm_fifo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ac97_pkg.sv
// ---------------------------------------------------------------------------
// ac97_pkg
// Shared definitions for the AC97 playback path: slot width, frame length,
// the stereo PCM pair carried through the playback FIFO, and the state
// encoding of the prime/run controller.
// ---------------------------------------------------------------------------
package ac97_pkg;

    localparam int AC97_SLOT_W     = 20;
    localparam int AC97_FRAME_BITS = 256;

    typedef struct packed {
        logic [AC97_SLOT_W-1:0] left;
        logic [AC97_SLOT_W-1:0] right;
    } pcm_pair_t;

    localparam int PCM_PAIR_W = $bits(pcm_pair_t);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } pcm_fifo_state_t;

    // Event counters stick at all-ones rather than wrapping, so a large
    // value is always a lower bound on the true count.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ac97_sync_fifo.sv
// ---------------------------------------------------------------------------
// ac97_sync_fifo
// Single-clock FIFO of stereo PCM pairs. Occupancy is tracked in an explicit
// level register; full/empty come from the level, so the pointers can wrap
// naturally at their own width. Read data is registered: a pop loads the head
// pair into rd_data_o on the same edge, rd_clr_i zeroes it, flush clears
// everything.
//
// Ports
//   clk_i        clock (posedge)
//   rst_i        synchronous active-high reset
//   flush_i      synchronous clear of contents, pointers and read data
//   push_i       write push_data_i (ignored when full, flushing or in reset)
//   push_data_i  pair to write
//   pop_i        load head pair into rd_data_o and advance (ignored when empty)
//   rd_clr_i     zero rd_data_o when no pop happens this cycle
//   rd_data_o    registered read data
//   level_o      occupancy 0..2**DEPTH_LOG2
//   full_o       level_o == 2**DEPTH_LOG2
//   empty_o      level_o == 0
// ---------------------------------------------------------------------------
module ac97_sync_fifo
    import ac97_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [PCM_PAIR_W-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  rd_clr_i,
    output logic [PCM_PAIR_W-1:0] rd_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    pcm_pair_t               mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q,  level_d;
    pcm_pair_t               rd_data_q, rd_data_d;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (level_q == DEPTH_LVL);
    assign empty_o = (level_q == '0);

    // Guard the handshakes here as well so the FIFO never corrupts its own
    // level, whatever the caller does.
    assign do_push = push_i && !full_o  && !flush_i && !rst_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i && !rst_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            rd_data_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
            end else if (rd_clr_i) begin
                rd_data_d = '0;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: a location is only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;

endmodule

// File: rtl/ac97_pcm_fifo.sv
// ---------------------------------------------------------------------------
// ac97_pcm_fifo
// Playback sample buffer in front of the AC-link serializer. Stereo pairs are
// accepted over a valid/ready handshake, buffered, and one pair is presented
// per frame strobe on slot3 (left) / slot4 (right). Playback starts only once
// START_LEVEL pairs are buffered; an empty FIFO at a strobe in RUN emits
// silence, counts an underrun and drops back to priming.
//
// State | meaning
// ------+-----------------------------------------------------------------
// PRIME | filling; strobes emit silence until level >= START_LEVEL, then
//       | that same strobe pops the first pair and enters RUN
// RUN   | one pop per strobe; empty at a strobe is an underrun -> PRIME
//
// Ports
//   ac97_bitclk           clock (posedge)
//   ac97_rst              synchronous active-high reset
//   ac97_strobe           one-cycle frame pulse, one pop opportunity each
//   flush                 clear FIFO and outputs, return to PRIME
//   in_valid/in_ready     producer handshake
//   in_left/in_right      20-bit MSB-aligned two's complement samples
//   ac97_out_slot3(_valid) left sample and tag bit to the link
//   ac97_out_slot4(_valid) right sample and tag bit to the link
//   level                 FIFO occupancy
//   underrun_count        saturating underrun event count
// ---------------------------------------------------------------------------
module ac97_pcm_fifo
    import ac97_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int START_LEVEL = 8
) (
    input  logic                   ac97_bitclk,
    input  logic                   ac97_rst,
    input  logic                   ac97_strobe,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AC97_SLOT_W-1:0] in_left,
    input  logic [AC97_SLOT_W-1:0] in_right,
    output logic [AC97_SLOT_W-1:0] ac97_out_slot3,
    output logic                   ac97_out_slot3_valid,
    output logic [AC97_SLOT_W-1:0] ac97_out_slot4,
    output logic                   ac97_out_slot4_valid,
    output logic [DEPTH_LOG2:0]    level,
    output logic [15:0]            underrun_count
);

    generate
        if (START_LEVEL < 1 || START_LEVEL > (1 << DEPTH_LOG2)) begin : g_bad_start_level
            $error("ac97_pcm_fifo: START_LEVEL must be in 1..2**DEPTH_LOG2");
        end
    endgenerate

    localparam logic [DEPTH_LOG2:0] START_LVL = (DEPTH_LOG2 + 1)'(START_LEVEL);

    pcm_fifo_state_t          state_q, state_d;
    logic                     valid_q, valid_d;
    logic [15:0]              underrun_count_q, underrun_count_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DEPTH_LOG2:0]      fifo_level;
    logic [PCM_PAIR_W-1:0]    fifo_rd_data;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_rd_clr;
    pcm_pair_t                push_pair;
    pcm_pair_t                slot_pair;

    // Ready depends on the registered level only, so a pop in the full cycle
    // cannot open the handshake until the following cycle.
    assign in_ready  = !fifo_full && !flush && !ac97_rst;
    assign fifo_push = in_valid && in_ready;

    assign push_pair.left  = in_left;
    assign push_pair.right = in_right;

    ac97_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i       (ac97_bitclk),
        .rst_i       (ac97_rst),
        .flush_i     (flush),
        .push_i      (fifo_push),
        .push_data_i (push_pair),
        .pop_i       (fifo_pop),
        .rd_clr_i    (fifo_rd_clr),
        .rd_data_o   (fifo_rd_data),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // The FIFO read register doubles as the slot data register: it is loaded
    // by a pop and zeroed on silent strobes, flush and reset, so the slots
    // only change on those edges.
    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        underrun_count_d = underrun_count_q;
        fifo_pop         = 1'b0;
        fifo_rd_clr      = 1'b0;

        if (flush) begin
            state_d = PRIME;
            valid_d = 1'b0;
        end else if (ac97_strobe) begin
            unique case (state_q)
                PRIME: begin
                    if (fifo_level >= START_LVL) begin
                        fifo_pop = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = RUN;
                    end else begin
                        fifo_rd_clr = 1'b1;
                        valid_d     = 1'b0;
                    end
                end
                RUN: begin
                    // Decided on the registered level: a pair pushed on this
                    // same edge still lands in the FIFO for a later frame.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        valid_d  = 1'b1;
                    end else begin
                        fifo_rd_clr      = 1'b1;
                        valid_d          = 1'b0;
                        underrun_count_d = sat_inc16(underrun_count_q);
                        state_d          = PRIME;
                    end
                end
                default: begin
                    state_d = PRIME;
                end
            endcase
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            state_q          <= PRIME;
            valid_q          <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign slot_pair            = fifo_rd_data;
    assign ac97_out_slot3       = slot_pair.left;
    assign ac97_out_slot4       = slot_pair.right;
    assign ac97_out_slot3_valid = valid_q;
    assign ac97_out_slot4_valid = valid_q;
    assign level                = fifo_level;
    assign underrun_count       = underrun_count_q;

endmodule
